// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: pops stereo words from the TX FIFO and serialises them
// MSB-first in Philips format, generating sck and ws from clk via a programmable prescaler.
//
// state | meaning
// IDLE  | outputs parked low, waiting for enable
// RUN   | prescaler running, frames shifted out on sck falling edges
module i2s_tx_sequencer #(
  parameter int SAMPLE_W = 16,
  parameter int DIV_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DIV_W-1:0]      clk_div,
  input  logic [2*SAMPLE_W-1:0] fifo_data,
  input  logic                  fifo_valid,
  output logic                  fifo_ack,
  output logic                  sck,
  output logic                  ws,
  output logic                  sd,
  output logic                  busy,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] WS_FIRST = BIT_W'(SAMPLE_W - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t               state_q, state_nxt;
  logic [DIV_W-1:0]     div_q, div_nxt;
  logic                 sck_q, sck_nxt;
  logic                 ws_q, ws_nxt;
  logic                 sd_q, sd_nxt;
  logic [BIT_W-1:0]     bit_q, bit_nxt;
  logic [FRAME_W-1:0]   shift_q, shift_nxt;
  logic                 underrun_q, underrun_nxt;
  logic                 underrun_set;
  logic                 load_ack;
  logic                 div_hit;
  logic                 fall_tick;
  logic                 frame_end;

  // >= rather than == also recovers cleanly if clk_div shrinks below the running count
  assign div_hit   = (div_q >= clk_div);
  assign fall_tick = (state_q == ST_RUN) && div_hit && sck_q;
  assign frame_end = (bit_q == LAST_BIT);

  function automatic logic ws_for(input logic [BIT_W-1:0] b);
    return (b >= WS_FIRST) && (b != LAST_BIT);
  endfunction

  always_comb begin
    state_nxt    = state_q;
    div_nxt      = div_q;
    sck_nxt      = sck_q;
    ws_nxt       = ws_q;
    sd_nxt       = sd_q;
    bit_nxt      = bit_q;
    shift_nxt    = shift_q;
    underrun_set = 1'b0;
    load_ack     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        div_nxt = '0;
        sck_nxt = 1'b0;
        ws_nxt  = 1'b0;
        sd_nxt  = 1'b0;
        bit_nxt = LAST_BIT;
        if (enable) begin
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        if (div_hit) begin
          div_nxt = '0;
          sck_nxt = ~sck_q;
        end else begin
          div_nxt = div_q + 1'b1;
        end

        if (fall_tick) begin
          if (frame_end && !enable) begin
            state_nxt = ST_IDLE;
            bit_nxt   = LAST_BIT;
            ws_nxt    = 1'b0;
            sd_nxt    = 1'b0;
            shift_nxt = '0;
          end else begin
            bit_nxt = frame_end ? '0 : bit_q + 1'b1;
            if (frame_end) begin
              if (fifo_valid) begin
                shift_nxt = fifo_data;
                load_ack  = 1'b1;
              end else begin
                shift_nxt    = '0;
                underrun_set = 1'b1;
              end
            end else begin
              shift_nxt = {shift_q[FRAME_W-2:0], 1'b0};
            end
            sd_nxt = shift_nxt[FRAME_W-1];
            ws_nxt = ws_for(bit_nxt);
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    underrun_nxt = underrun_set | (underrun_q & ~underrun_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      sck_q      <= 1'b0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      bit_q      <= LAST_BIT;
      shift_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      div_q      <= div_nxt;
      sck_q      <= sck_nxt;
      ws_q       <= ws_nxt;
      sd_q       <= sd_nxt;
      bit_q      <= bit_nxt;
      shift_q    <= shift_nxt;
      underrun_q <= underrun_nxt;
    end
  end

  // Pop is combinational so the FIFO advances on the same edge that loads the shifter
  assign fifo_ack = load_ack & rst_n;
  assign sck      = sck_q;
  assign ws       = ws_q;
  assign sd       = sd_q;
  assign busy     = (state_q == ST_RUN);
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Bench for i2s_tx_sequencer: expected frame words are queued as stimulus is planned and
// compared bit-by-bit against sd/ws at every sck rising edge.
module tb_i2s_tx_sequencer;

  localparam int SW = 16;
  localparam int DW = 8;
  localparam int FW = 2 * SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] clk_div = 8'd1;
  logic [FW-1:0] fifo_data = '0;
  logic          fifo_valid = 1'b0;
  logic          underrun_clr = 1'b0;
  logic          fifo_ack, sck, ws, sd, busy, underrun;

  i2s_tx_sequencer #(.SAMPLE_W(SW), .DIV_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clk_div(clk_div),
    .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ack(fifo_ack),
    .sck(sck), .ws(ws), .sd(sd), .busy(busy), .underrun(underrun),
    .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] cur_word = '0;
  int            ack_times[$];
  int            ack_cnt = 0;
  int            edge_idx = 0;
  int            frame_k = -1;
  int            last_k = -1;
  int            mon_k;
  logic          prev_sck = 1'b0;
  logic          exp_ws;

  // Scoreboard monitor: edge 0 of a run is the idle lead-in bit, then frame bits follow.
  always @(negedge clk) begin
    if (fifo_ack === 1'b1) begin
      ack_times.push_back(cyc);
      ack_cnt++;
      total++;
      if (fifo_valid !== 1'b1) begin
        bad++;
        $display("FAIL ack_without_valid cyc=%0d fifo_valid=%b expected 1", cyc, fifo_valid);
      end
    end
    if (busy !== 1'b1) begin
      edge_idx = 0;
      frame_k  = -1;
    end else if (sck === 1'b1 && prev_sck === 1'b0) begin
      if (edge_idx == 0) begin
        total++;
        if (sd !== 1'b0 || ws !== 1'b0) begin
          bad++;
          $display("FAIL lead_in_bit sd=%b ws=%b expected 0 0", sd, ws);
        end
      end else begin
        mon_k = (edge_idx - 1) % FW;
        if (mon_k == 0) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty unexpected frame at cyc=%0d", cyc);
            cur_word = '0;
          end else begin
            cur_word = exp_q.pop_front();
          end
        end
        exp_ws = (mon_k >= SW - 1) && (mon_k <= FW - 2);
        total++;
        if (sd !== cur_word[FW-1-mon_k] || ws !== exp_ws) begin
          bad++;
          $display("FAIL frame_bit k=%0d word=%h sd=%b ws=%b expected sd=%b ws=%b",
                   mon_k, cur_word, sd, ws, cur_word[FW-1-mon_k], exp_ws);
        end
        frame_k = mon_k;
        last_k  = mon_k;
      end
      edge_idx++;
    end
    prev_sck = sck;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int target, input int budget);
    int i = 0;
    while (ack_cnt < target && i < budget) begin tick(); i++; end
  endtask

  task automatic wait_k(input int target, input int budget);
    int i = 0;
    while (frame_k != target && i < budget) begin tick(); i++; end
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy !== 1'b0 && i < budget) begin tick(); i++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; fifo_valid = 1'b1; fifo_data = 32'hA5A5_3C3C; clk_div = 8'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({sck, ws, sd, busy, underrun, fifo_ack} !== 6'b0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d got=%b expected 000000", i,
                 {sck, ws, sd, busy, underrun, fifo_ack});
      end
    end
    enable = 1'b0; fifo_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (ack_cnt !== 0) begin
      bad++;
      $display("FAIL reset_ack acks=%0d expected 0", ack_cnt);
    end
  endtask

  task automatic test_main();
    logic [FW-1:0] w[3];
    int base, t0;
    w[0] = 32'hA5A5_3C3C; w[1] = 32'h1234_5678; w[2] = 32'hFFFF_0001;
    for (int i = 0; i < 3; i++) exp_q.push_back(w[i]);
    clk_div = 8'd1; fifo_valid = 1'b1; fifo_data = w[0];
    base = ack_cnt; ack_times.delete();
    t0 = cyc; enable = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      wait_acks(base + n, 200);
      if (n < 3) fifo_data = w[n];
    end
    enable = 1'b0;
    wait_idle(300);
    total++;
    if (ack_cnt !== base + 3 || ack_times.size() !== 3) begin
      bad++;
      $display("FAIL main_acks acks=%0d expected %0d", ack_cnt - base, 3);
    end else begin
      total++;
      if (ack_times[0] - t0 !== 4) begin
        bad++;
        $display("FAIL main_first_ack latency=%0d expected 4", ack_times[0] - t0);
      end
      for (int i = 1; i < 3; i++) begin
        total++;
        if (ack_times[i] - ack_times[i-1] !== 128) begin
          bad++;
          $display("FAIL main_ack_interval got=%0d expected 128", ack_times[i] - ack_times[i-1]);
        end
      end
    end
    total++;
    if ({busy, sck, ws, sd} !== 4'b0 || exp_q.size() !== 0 || last_k !== FW - 1) begin
      bad++;
      $display("FAIL main_stop busy/sck/ws/sd=%b left=%0d last_k=%0d expected 0000 0 31",
               {busy, sck, ws, sd}, exp_q.size(), last_k);
    end
  endtask

  task automatic test_underrun();
    int base;
    clk_div = 8'd1; fifo_valid = 1'b0;
    exp_q.push_back('0);
    base = ack_cnt;
    total++;
    if (underrun !== 1'b0) begin
      bad++;
      $display("FAIL underrun_pre got=%b expected 0", underrun);
    end
    enable = 1'b1;
    repeat (4) tick();
    underrun_clr = 1'b1;
    total++;
    if (underrun !== 1'b0) begin
      bad++;
      $display("FAIL underrun_before_load got=%b expected 0", underrun);
    end
    tick();
    underrun_clr = 1'b0;
    total++;
    if (underrun !== 1'b1) begin
      bad++;
      $display("FAIL underrun_set_over_clr got=%b expected 1", underrun);
    end
    enable = 1'b0;
    wait_idle(300);
    total++;
    if (ack_cnt !== base || underrun !== 1'b1 || exp_q.size() !== 0 || last_k !== FW - 1) begin
      bad++;
      $display("FAIL underrun_frame acks=%0d underrun=%b left=%0d last_k=%0d expected 0 1 0 31",
               ack_cnt - base, underrun, exp_q.size(), last_k);
    end
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    total++;
    if (underrun !== 1'b0) begin
      bad++;
      $display("FAIL underrun_clear got=%b expected 0", underrun);
    end
  endtask

  task automatic test_stop();
    int base;
    clk_div = 8'd1; fifo_valid = 1'b1; fifo_data = 32'hC0FF_EE11;
    exp_q.push_back(32'hC0FF_EE11);
    base = ack_cnt; enable = 1'b1;
    wait_acks(base + 1, 50);
    wait_k(5, 300);
    enable = 1'b0;
    wait_idle(300);
    total++;
    if (ack_cnt !== base + 1 || {busy, sck, ws, sd} !== 4'b0 || last_k !== FW - 1 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL stop_drain acks=%0d busy/sck/ws/sd=%b last_k=%0d left=%0d expected 1 0000 31 0",
               ack_cnt - base, {busy, sck, ws, sd}, last_k, exp_q.size());
    end
    fifo_data = 32'h5A5A_0F0F;
    exp_q.push_back(32'h5A5A_0F0F);
    exp_q.push_back(32'h5A5A_0F0F);
    base = ack_cnt; enable = 1'b1;
    wait_acks(base + 1, 50);
    wait_k(5, 300);
    enable = 1'b0;
    wait_k(20, 300);
    enable = 1'b1;
    wait_acks(base + 2, 300);
    total++;
    if (ack_cnt !== base + 2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL stop_reassert acks=%0d busy=%b expected 2 1", ack_cnt - base, busy);
    end
    enable = 1'b0;
    wait_idle(300);
    total++;
    if (ack_cnt !== base + 2 || last_k !== FW - 1 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL stop_reassert_end acks=%0d last_k=%0d left=%0d expected 2 31 0",
               ack_cnt - base, last_k, exp_q.size());
    end
  endtask

  task automatic test_clkdiv0();
    int base, t0;
    logic prev;
    clk_div = 8'd0; fifo_valid = 1'b1; fifo_data = 32'h8000_0001;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h8000_0001);
    base = ack_cnt; ack_times.delete();
    t0 = cyc; enable = 1'b1;
    wait_acks(base + 1, 20);
    prev = sck;
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if (sck === prev) begin
        bad++;
        $display("FAIL div0_sck_toggle cycle=%0d sck=%b expected %b", i, sck, ~prev);
      end
      prev = sck;
    end
    wait_acks(base + 4, 300);
    enable = 1'b0;
    wait_idle(200);
    total++;
    if (ack_times.size() !== 4) begin
      bad++;
      $display("FAIL div0_acks acks=%0d expected 4", ack_times.size());
    end else begin
      total++;
      if (ack_times[0] - t0 !== 2) begin
        bad++;
        $display("FAIL div0_first_ack latency=%0d expected 2", ack_times[0] - t0);
      end
      for (int i = 1; i < 4; i++) begin
        total++;
        if (ack_times[i] - ack_times[i-1] !== 64) begin
          bad++;
          $display("FAIL div0_ack_interval got=%0d expected 64", ack_times[i] - ack_times[i-1]);
        end
      end
    end
    total++;
    if (exp_q.size() !== 0 || last_k !== FW - 1) begin
      bad++;
      $display("FAIL div0_end left=%0d last_k=%0d expected 0 31", exp_q.size(), last_k);
    end
  endtask

  task automatic test_reset_mid();
    int base, t0;
    clk_div = 8'd1; fifo_valid = 1'b1; fifo_data = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'h0BAD_F00D);
    base = ack_cnt; enable = 1'b1;
    wait_acks(base + 1, 50);
    fifo_data = 32'h0BAD_F00D;
    wait_k(10, 300);
    rst_n = 1'b0;
    tick();
    total++;
    if ({busy, sck, ws, sd, underrun, fifo_ack} !== 6'b0 || ack_cnt !== base + 1) begin
      bad++;
      $display("FAIL mid_reset outputs=%b acks=%0d expected 000000 1",
               {busy, sck, ws, sd, underrun, fifo_ack}, ack_cnt - base);
    end
    ack_times.delete();
    t0 = cyc;
    rst_n = 1'b1;
    wait_acks(base + 2, 50);
    total++;
    if (ack_times.size() !== 1 || ack_times[0] - t0 !== 4) begin
      bad++;
      $display("FAIL mid_reset_restart acks=%0d latency=%0d expected 1 4",
               ack_times.size(), (ack_times.size() > 0) ? ack_times[0] - t0 : -1);
    end
    enable = 1'b0;
    wait_idle(300);
    total++;
    if (exp_q.size() !== 0 || last_k !== FW - 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_end left=%0d last_k=%0d busy=%b expected 0 31 0",
               exp_q.size(), last_k, busy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_main();
    test_underrun();
    test_stop();
    test_clkdiv0();
    test_reset_mid();
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
